// File: rtl/axis_frame_gen.sv
// AXI-Stream ramp-frame source: every pixel byte carries the pixel's x index,
// with row/frame boundaries flagged on tuser (SOF/EOF/SOL/EOL) and tlast.
module axis_frame_gen #(
  parameter int SIZE_WIDTH = 13,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aclk_reset,
  input  logic                  aclk_start,
  input  logic [2:0]            aclk_pixel_width,
  input  logic [SIZE_WIDTH-1:0] aclk_x_size,
  input  logic [SIZE_WIDTH-1:0] aclk_y_size,
  input  logic [GAP_WIDTH-1:0]  aclk_row_gap,
  input  logic                  aclk_tready,
  output logic                  aclk_tvalid,
  output logic [63:0]           aclk_tdata,
  output logic [3:0]            aclk_tuser,
  output logic                  aclk_tlast,
  output logic                  aclk_busy,
  output logic                  aclk_frame_done,
  output logic                  aclk_cfg_err
);
  localparam int BEAT_W = SIZE_WIDTH + 1;
  localparam int BYTE_W = SIZE_WIDTH + 4;
  localparam int ROWB_W = SIZE_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, GAP, ROW} state_t;
  state_t state, state_nxt;

  logic [1:0]            pw_log2_in, pw_log2_q;
  logic                  pw_legal;
  logic [SIZE_WIDTH-1:0] x_size_q, y_size_q, row_cnt;
  logic [GAP_WIDTH-1:0]  row_gap_q, gap_cnt;
  logic [BEAT_W-1:0]     beats_in, beats_q, beat_cnt;
  logic [ROWB_W-1:0]     row_bytes, row_bytes_rnd;
  logic                  start_ok, start_bad, fire;
  logic                  first_beat, last_beat, last_row;
  logic                  frame_done_q, cfg_err_q;
  logic [63:0]           ramp_data;

  // An 8-byte pixel cannot be written in 3 bits, so width code 0 stands for 8.
  always_comb begin
    pw_legal   = 1'b1;
    pw_log2_in = 2'd0;
    case (aclk_pixel_width)
      3'd1:    pw_log2_in = 2'd0;
      3'd2:    pw_log2_in = 2'd1;
      3'd4:    pw_log2_in = 2'd2;
      3'd0:    pw_log2_in = 2'd3;
      default: pw_legal   = 1'b0;
    endcase
  end

  assign row_bytes     = ROWB_W'(aclk_x_size) << pw_log2_in;
  assign row_bytes_rnd = row_bytes + ROWB_W'(7);
  assign beats_in      = BEAT_W'(row_bytes_rnd >> 3);

  assign start_ok   = (state == IDLE) && aclk_start && pw_legal &&
                      (aclk_x_size != '0) && (aclk_y_size != '0);
  assign start_bad  = (state == IDLE) && aclk_start && !start_ok;
  assign fire       = (state == ROW) && aclk_tready;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == beats_q - BEAT_W'(1));
  assign last_row   = (row_cnt == y_size_q - SIZE_WIDTH'(1));

  for (genvar k = 0; k < 8; k++) begin : g_byte
    logic [BYTE_W-1:0] byte_idx, pix_idx;
    assign byte_idx = {beat_cnt, 3'(k)};
    assign pix_idx  = byte_idx >> pw_log2_q;
    assign ramp_data[8*k +: 8] = (pix_idx < BYTE_W'(x_size_q)) ? pix_idx[7:0] : 8'h00;
  end

  always_comb begin
    state_nxt   = state;
    aclk_tvalid = 1'b0;
    aclk_tdata  = '0;
    aclk_tuser  = '0;
    aclk_tlast  = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = GAP;
      GAP:  if (gap_cnt == '0) state_nxt = ROW;
      ROW: begin
        aclk_tvalid   = 1'b1;
        aclk_tdata    = ramp_data;
        aclk_tuser[0] = first_beat && (row_cnt == '0);
        aclk_tuser[2] = first_beat && (row_cnt != '0);
        aclk_tuser[1] = last_beat && last_row;
        aclk_tuser[3] = last_beat && !last_row;
        aclk_tlast    = last_beat;
        // A zero gap skips GAP entirely so rows run back to back.
        if (fire && last_beat) begin
          if (last_row)              state_nxt = IDLE;
          else if (row_gap_q == '0)  state_nxt = ROW;
          else                       state_nxt = GAP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign aclk_busy       = (state != IDLE);
  assign aclk_frame_done = frame_done_q;
  assign aclk_cfg_err    = cfg_err_q;

  // The first GAP also spends the start cycle, later gaps reload with row_gap-1.
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state        <= IDLE;
      pw_log2_q    <= '0;
      x_size_q     <= '0;
      y_size_q     <= '0;
      row_gap_q    <= '0;
      beats_q      <= '0;
      gap_cnt      <= '0;
      beat_cnt     <= '0;
      row_cnt      <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= fire && last_beat && last_row;
      cfg_err_q    <= start_bad;
      if (start_ok) begin
        pw_log2_q <= pw_log2_in;
        x_size_q  <= aclk_x_size;
        y_size_q  <= aclk_y_size;
        row_gap_q <= aclk_row_gap;
        beats_q   <= beats_in;
        gap_cnt   <= aclk_row_gap;
        beat_cnt  <= '0;
        row_cnt   <= '0;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
      end else if (fire) begin
        if (last_beat) begin
          beat_cnt <= '0;
          row_cnt  <= row_cnt + SIZE_WIDTH'(1);
          gap_cnt  <= row_gap_q - GAP_WIDTH'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: directed frames push expected beats,
// a negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_axis_frame_gen;
  localparam int SW = 13;
  localparam int GW = 16;

  logic          aclk = 1'b0;
  logic          aclk_reset, aclk_start, aclk_tready;
  logic [2:0]    aclk_pixel_width;
  logic [SW-1:0] aclk_x_size, aclk_y_size;
  logic [GW-1:0] aclk_row_gap;
  logic          aclk_tvalid, aclk_tlast, aclk_busy, aclk_frame_done, aclk_cfg_err;
  logic [63:0]   aclk_tdata;
  logic [3:0]    aclk_tuser;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t cap[0:255];
  beat_t mon_cur, mon_exp, held;
  int    checks = 0, errors = 0;
  int    cap_idx = 0, beats_seen = 0, done_cnt = 0, cfg_err_cnt = 0;
  int    cur_gap = 0, low_run = 0, gap_want = 0;
  bit    first_checked = 1'b0, prev_stall = 1'b0;

  always #5 aclk = ~aclk;

  axis_frame_gen #(.SIZE_WIDTH(SW), .GAP_WIDTH(GW)) dut (
    .aclk(aclk), .aclk_reset(aclk_reset), .aclk_start(aclk_start),
    .aclk_pixel_width(aclk_pixel_width), .aclk_x_size(aclk_x_size),
    .aclk_y_size(aclk_y_size), .aclk_row_gap(aclk_row_gap),
    .aclk_tready(aclk_tready), .aclk_tvalid(aclk_tvalid), .aclk_tdata(aclk_tdata),
    .aclk_tuser(aclk_tuser), .aclk_tlast(aclk_tlast), .aclk_busy(aclk_busy),
    .aclk_frame_done(aclk_frame_done), .aclk_cfg_err(aclk_cfg_err)
  );

  // Monitor: stall stability, row-gap lengths, scoreboard pops, pulse counting.
  always @(negedge aclk) begin
    mon_cur = {aclk_tdata, aclk_tuser, aclk_tlast};
    if (aclk_reset) begin
      low_run = 0; prev_stall = 1'b0; first_checked = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!aclk_tvalid || mon_cur !== held) begin
          errors++;
          $display("[TB] FAIL stall_hold: got valid=%0b %h/%b/%b, want valid=1 %h/%b/%b",
                   aclk_tvalid, mon_cur.data, mon_cur.user, mon_cur.last,
                   held.data, held.user, held.last);
        end
      end
      prev_stall = aclk_tvalid && !aclk_tready;
      held = mon_cur;
      if (!aclk_busy) low_run = 0;
      else if (!aclk_tvalid) low_run++;
      if (aclk_tvalid && (aclk_tuser[0] || aclk_tuser[2]) && !first_checked) begin
        gap_want = aclk_tuser[0] ? cur_gap + 1 : cur_gap;
        checks++;
        if (low_run != gap_want) begin
          errors++;
          $display("[TB] FAIL row_gap: got %0d idle cycles, want %0d", low_run, gap_want);
        end
        first_checked = 1'b1;
      end
      if (aclk_tvalid) low_run = 0;
      if (aclk_tvalid && aclk_tready) begin
        first_checked = 1'b0;
        beats_seen++;
        if (cap_idx < 256) cap[cap_idx] = mon_cur;
        cap_idx++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL beat_unexpected: got %h/%b/%b, want no beat",
                   mon_cur.data, mon_cur.user, mon_cur.last);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp) begin
            errors++;
            $display("[TB] FAIL beat %0d: got %h/%b/%b, want %h/%b/%b", cap_idx - 1,
                     mon_cur.data, mon_cur.user, mon_cur.last,
                     mon_exp.data, mon_exp.user, mon_exp.last);
          end
        end
      end
      if (aclk_frame_done) begin
        done_cnt++;
        checks++;
        if (aclk_busy) begin
          errors++;
          $display("[TB] FAIL done_busy: got busy=1, want 0");
        end
      end
      if (aclk_cfg_err) cfg_err_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic pushBeat(input logic [63:0] d, input logic [3:0] u, input logic l);
    beat_t b;
    b.data = d; b.user = u; b.last = l;
    exp_q.push_back(b);
  endtask

  // Reference model: division-based pixel index, independent of the shifter.
  task automatic pushModel(input int pw, input int x, input int y);
    int nbeats, n, p;
    logic [63:0] d;
    logic [3:0]  u;
    nbeats = (x * pw + 7) / 8;
    for (int r = 0; r < y; r++) begin
      for (int b = 0; b < nbeats; b++) begin
        d = '0;
        for (int k = 0; k < 8; k++) begin
          n = 8 * b + k;
          p = n / pw;
          if (p < x) d[8*k +: 8] = 8'(p);
        end
        u = '0;
        if (b == 0) u = (r == 0) ? 4'b0001 : 4'b0100;
        if (b == nbeats - 1) u = u | ((r == y - 1) ? 4'b0010 : 4'b1000);
        pushBeat(d, u, b == nbeats - 1);
      end
    end
  endtask

  // Config is scrambled right after the start cycle to prove it was latched.
  task automatic pulseStart(input int pw, input int x, input int y, input int gap);
    @(posedge aclk); #1;
    aclk_start = 1'b1; aclk_pixel_width = 3'(pw);
    aclk_x_size = SW'(x); aclk_y_size = SW'(y); aclk_row_gap = GW'(gap);
    @(posedge aclk); #1;
    aclk_start = 1'b0; aclk_pixel_width = 3'd4;
    aclk_x_size = SW'(3); aclk_y_size = SW'(1); aclk_row_gap = GW'(2);
  endtask

  task automatic applyStimulus(input int pw, input int x, input int y, input int gap,
                               input bit rand_ready, input bit poke, input bit use_model);
    int d0, e0, cyc;
    cur_gap = gap; cap_idx = 0; d0 = done_cnt; e0 = cfg_err_cnt;
    if (use_model) pushModel(pw, x, y);
    aclk_tready = 1'b1;
    pulseStart(pw, x, y, gap);
    cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin
      @(posedge aclk); #1;
      aclk_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      aclk_start  = poke && (cyc == 20);
      cyc++;
    end
    aclk_start = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("frame_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("no_cfg_err", 64'(cfg_err_cnt - e0), 64'd0);
    checkOutput("idle_after_frame", {63'd0, aclk_busy}, 64'd0);
    exp_q.delete();
  endtask

  task automatic applyBadStart(input int pw, input int x, input int y);
    int e0;
    bit seen;
    e0 = cfg_err_cnt; seen = 1'b0;
    pulseStart(pw, x, y, 0);
    repeat (4) begin
      @(negedge aclk);
      if (aclk_tvalid || aclk_busy) seen = 1'b1;
    end
    checkOutput("cfg_err_pulses", 64'(cfg_err_cnt - e0), 64'd1);
    checkOutput("bad_start_quiet", {63'd0, seen}, 64'd0);
  endtask

  initial begin
    int base, cyc, d0;
    aclk_reset = 1'b1; aclk_start = 1'b0; aclk_tready = 1'b0;
    aclk_pixel_width = 3'd1; aclk_x_size = '0; aclk_y_size = '0; aclk_row_gap = '0;
    repeat (3) @(posedge aclk);
    #1;
    aclk_reset = 1'b0;
    checkOutput("reset_tvalid", {63'd0, aclk_tvalid}, 64'd0);
    checkOutput("reset_busy", {63'd0, aclk_busy}, 64'd0);
    checkOutput("reset_tdata", aclk_tdata, 64'd0);
    checkOutput("reset_flags", {57'd0, aclk_tuser, aclk_tlast, aclk_frame_done, aclk_cfg_err}, 64'd0);

    $display("[TB] 256x5 ramp, pw=1, gap=0, full ready");
    applyStimulus(1, 256, 5, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("s1_beats", 64'(cap_idx), 64'd160);
    checkOutput("s1_first_data", cap[0].data, 64'h0706050403020100);
    checkOutput("s1_first_user", 64'(cap[0].user), 64'h1);
    checkOutput("s1_row1_user", 64'(cap[32].user), 64'h4);
    checkOutput("s1_last_data", cap[159].data, 64'hFFFEFDFCFBFAF9F8);
    checkOutput("s1_last_user", 64'(cap[159].user), 64'h2);
    checkOutput("s1_last_tlast", 64'(cap[159].last), 64'h1);

    $display("[TB] 10x2, pw=2");
    pushBeat(64'h0303020201010000, 4'b0001, 1'b0);
    pushBeat(64'h0707060605050404, 4'b0000, 1'b0);
    pushBeat(64'h0000000009090808, 4'b1000, 1'b1);
    pushBeat(64'h0303020201010000, 4'b0100, 1'b0);
    pushBeat(64'h0707060605050404, 4'b0000, 1'b0);
    pushBeat(64'h0000000009090808, 4'b0010, 1'b1);
    applyStimulus(2, 10, 2, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_beats", 64'(cap_idx), 64'd6);

    $display("[TB] 256x5 ramp, pw=1, gap=7, random ready");
    applyStimulus(1, 256, 5, 7, 1'b1, 1'b0, 1'b1);

    $display("[TB] 8x1 single beat");
    pushBeat(64'h0706050403020100, 4'b0011, 1'b1);
    applyStimulus(1, 8, 1, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] rejected starts");
    applyBadStart(3, 16, 2);
    applyBadStart(1, 0, 2);
    applyBadStart(2, 16, 0);

    $display("[TB] reset at beat 10 of row 2");
    cur_gap = 0; d0 = done_cnt;
    pushModel(1, 256, 5);
    while (exp_q.size() > 74) void'(exp_q.pop_back());
    base = beats_seen; aclk_tready = 1'b1;
    pulseStart(1, 256, 5, 0);
    cyc = 0;
    while (beats_seen - base < 74 && cyc < 500) begin
      @(posedge aclk); #1;
      cyc++;
    end
    checkOutput("reset_point_reached", 64'(beats_seen - base), 64'd74);
    aclk_reset = 1'b1;
    @(posedge aclk); #1;
    aclk_reset = 1'b0;
    checkOutput("midreset_tvalid", {63'd0, aclk_tvalid}, 64'd0);
    checkOutput("midreset_busy", {63'd0, aclk_busy}, 64'd0);
    checkOutput("midreset_flags", {59'd0, aclk_tuser, aclk_tlast}, 64'd0);
    checkOutput("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    checkOutput("midreset_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    applyStimulus(1, 256, 5, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("restart_sof", 64'(cap[0].user), 64'h1);
    checkOutput("restart_beats", 64'(cap_idx), 64'd160);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
